// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU-control opcodes used by the ALU and the ALU-control decoder
package alu_pkg;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
endpackage

// File: rtl/mips_alu_addsub.sv
// mips_alu_addsub: WIDTH+1-bit adder/subtractor (a, b, sub in; sum, carry=carry-out or borrow, overflow out)
module mips_alu_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);
  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   full;
  assign bx       = sub ? ~b : b;
  assign full     = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};
  assign sum      = full[WIDTH-1:0];
  assign carry    = full[WIDTH] ^ sub;
  assign overflow = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
endmodule

// File: rtl/mips_alu.sv
// mips_alu: MIPS execute-stage ALU (clk, rst_n, alucontrol, operand_a/b in; aluout, zero, carry, overflow comb; aluout_q, flags_q registered)
module mips_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       alucontrol,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] aluout,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic [WIDTH-1:0] aluout_q,
  output logic [3:0]       flags_q
);
  logic             is_add, is_sub, is_slt;
  logic [WIDTH-1:0] sum;
  logic             as_carry, as_ovf;
  assign is_add = alucontrol == ALU_ADD;
  assign is_sub = alucontrol == ALU_SUB;
  assign is_slt = alucontrol == ALU_SLT;
  mips_alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a        (operand_a),
    .b        (operand_b),
    .sub      (is_sub || is_slt),
    .sum      (sum),
    .carry    (as_carry),
    .overflow (as_ovf)
  );
  always_comb begin
    aluout = alucontrol == ALU_AND ? operand_a & operand_b :
             alucontrol == ALU_OR  ? operand_a | operand_b :
             (is_add || is_sub)    ? sum :
             is_slt                ? {{(WIDTH-1){1'b0}}, as_carry} :
                                     '0;
    carry    = (is_add || is_sub) && as_carry;
    overflow = (is_add || is_sub) && as_ovf;
    zero     = aluout == '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aluout_q <= '0;
      flags_q  <= 4'b0000;
    end else begin
      aluout_q <= aluout;
      flags_q  <= {overflow, carry, aluout[WIDTH-1], zero};
    end
  end
endmodule

// File: tb/tb_mips_alu.sv
// tb_mips_alu: scoreboard bench for mips_alu at WIDTH=5
module tb_mips_alu;
  import alu_pkg::*;
  typedef struct {
    string      name;
    bit         chk_q;
    logic [4:0] out;
    logic       z, c, v;
    logic [4:0] q;
    logic [3:0] f;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] op = 4'b0;
  logic [4:0] a = 5'd0, b = 5'd0;
  logic [4:0] aluout, aluout_q;
  logic       zero, carry, overflow;
  logic [3:0] flags_q;
  exp_t       sb[$];
  int         passed = 0, total = 0;
  mips_alu #(.WIDTH(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alucontrol (op),
    .operand_a  (a),
    .operand_b  (b),
    .aluout     (aluout),
    .zero       (zero),
    .carry      (carry),
    .overflow   (overflow),
    .aluout_q   (aluout_q),
    .flags_q    (flags_q)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input string f, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s.%s: got %0d, expected %0d", n, f, act, exp);
  endtask
  initial begin
    exp_t e;
    forever begin
      wait (sb.size() > 0);
      e = sb.pop_front();
      chk(e.name, "aluout", int'(aluout), int'(e.out));
      chk(e.name, "zero", int'(zero), int'(e.z));
      chk(e.name, "carry", int'(carry), int'(e.c));
      chk(e.name, "overflow", int'(overflow), int'(e.v));
      if (e.chk_q) begin
        chk(e.name, "aluout_q", int'(aluout_q), int'(e.q));
        chk(e.name, "flags_q", int'(flags_q), int'(e.f));
      end
    end
  end
  task automatic push(input string n, input bit cq, input logic [4:0] o, input logic z, c, v,
                      input logic [4:0] q, input logic [3:0] f);
    exp_t e;
    e.name = n; e.chk_q = cq; e.out = o; e.z = z; e.c = c; e.v = v; e.q = q; e.f = f;
    sb.push_back(e);
  endtask
  task automatic vec(input string n, input logic [3:0] o, input logic [4:0] x, y,
                     input logic [4:0] r, input logic z, c, v);
    @(negedge clk);
    op = o; a = x; b = y;
    #1;
    push(n, 1'b0, r, z, c, v, 5'd0, 4'd0);
  endtask
  task automatic model(input logic [3:0] o, input int x, y,
                       output logic [4:0] r, output logic z, c, v);
    int sx, sy, s;
    sx = x >= 16 ? x - 32 : x;
    sy = y >= 16 ? y - 32 : y;
    r = 5'd0; c = 1'b0; v = 1'b0;
    case (o)
      ALU_AND: r = 5'(x & y);
      ALU_OR:  r = 5'(x | y);
      ALU_ADD: begin r = 5'((x + y) % 32); c = (x + y) >= 32; s = sx + sy; v = s > 15 || s < -16; end
      ALU_SUB: begin r = 5'((x - y + 32) % 32); c = x < y; s = sx - sy; v = s > 15 || s < -16; end
      ALU_SLT: r = x < y ? 5'd1 : 5'd0;
      default: r = 5'd0;
    endcase
    z = r == 5'd0;
  endtask
  initial begin
    logic [3:0] ops [6];
    logic [4:0] r;
    logic       z, c, v;
    int         x, y;
    ops = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, 4'b1011};
    #2;
    push("reset", 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    vec("add_20_15", ALU_ADD, 5'd20, 5'd15, 5'd3, 1'b0, 1'b1, 1'b0);
    vec("add_16_16", ALU_ADD, 5'd16, 5'd16, 5'd0, 1'b1, 1'b1, 1'b1);
    vec("sub_25_25", ALU_SUB, 5'd25, 5'd25, 5'd0, 1'b1, 1'b0, 1'b0);
    vec("sub_3_7",   ALU_SUB, 5'd3,  5'd7,  5'd28, 1'b0, 1'b1, 1'b0);
    vec("sub_16_1",  ALU_SUB, 5'd16, 5'd1,  5'd15, 1'b0, 1'b0, 1'b1);
    vec("slt_3_7",   ALU_SLT, 5'd3,  5'd7,  5'd1, 1'b0, 1'b0, 1'b0);
    vec("slt_7_3",   ALU_SLT, 5'd7,  5'd3,  5'd0, 1'b1, 1'b0, 1'b0);
    vec("slt_30_2",  ALU_SLT, 5'd30, 5'd2,  5'd0, 1'b1, 1'b0, 1'b0);
    vec("and_21_10", ALU_AND, 5'd21, 5'd10, 5'd0, 1'b1, 1'b0, 1'b0);
    vec("or_21_10",  ALU_OR,  5'd21, 5'd10, 5'd31, 1'b0, 1'b0, 1'b0);
    vec("op_1111",   4'b1111, 5'd21, 5'd10, 5'd0, 1'b1, 1'b0, 1'b0);
    vec("add_15_1",  ALU_ADD, 5'd15, 5'd1,  5'd16, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    push("reg_ovf", 1'b1, 5'd16, 1'b0, 1'b0, 1'b1, 5'd16, 4'b1010);
    vec("add_1_2", ALU_ADD, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    push("reg_add", 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 5'd3, 4'b0000);
    #2;
    rst_n = 1'b0;
    #1;
    push("reg_async_rst", 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 5'd0, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    push("reg_held", 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 5'd0, 4'b0000);
    @(posedge clk); #1;
    push("reg_resume", 1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 5'd3, 4'b0000);
    for (int i = 0; i < 60; i++) begin
      x = int'($urandom_range(0, 31));
      y = int'($urandom_range(0, 31));
      model(ops[i % 6], x, y, r, z, c, v);
      vec("sweep", ops[i % 6], 5'(x), 5'(y), r, z, c, v);
    end
    for (int i = 0; i < 100 && sb.size() > 0; i++) #1;
    total++;
    if (sb.size() != 0) $display("FAIL drain: %0d entries left, expected 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
